// File: rtl/wide_add_pkg.sv
// Shared types and default sizing for the chunked wide adder.
// Optional feature macro: WIDE_ADD_SUB_EN (adds subtraction).
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CHUNK_DEF  = 15;
    localparam int NCHUNK_DEF = 4;

endpackage

// File: rtl/wide_add_seq_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry slice with carry-in.
// Each bit is one full-adder cell.
module chunk_adder #(
    parameter int CHUNK = 15
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic p;
        assign p        = a[i] ^ b[i];
        assign sum[i]   = p ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (p & c[i]);
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: one shared slice, LS chunk first.
// Define WIDE_ADD_SUB_EN to add the in_sub port (A - B).
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int  CHUNK  = CHUNK_DEF,
    parameter int  NCHUNK = NCHUNK_DEF,
    localparam int W      = CHUNK * NCHUNK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
`ifdef WIDE_ADD_SUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         busy
);

    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_t            state;
    logic [IW-1:0]     idx;
    logic              carry;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      sum_q;
    logic [CHUNK-1:0]  sl_a;
    logic [CHUNK-1:0]  sl_b;
    logic [CHUNK-1:0]  sl_sum;
    logic              sl_cout;
    logic              init_c;

`ifdef WIDE_ADD_SUB_EN
    logic sub_q;
    assign init_c = in_sub;
    assign sl_b   = b_q[int'(idx)*CHUNK +: CHUNK] ^ {CHUNK{sub_q}};
`else
    assign init_c = 1'b0;
    assign sl_b   = b_q[int'(idx)*CHUNK +: CHUNK];
`endif

    assign sl_a = a_q[int'(idx)*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    assign out_sum = sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        idx      <= '0;
                        carry    <= init_c;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef WIDE_ADD_SUB_EN
                        sub_q    <= in_sub;
`endif
                    end
                end
                RUN: begin
                    sum_q[int'(idx)*CHUNK +: CHUNK] <= sl_sum;
                    carry <= sl_cout;
                    if (idx == LAST) begin
                        // top-chunk carry leaves only via out_cout
                        idx       <= '0;
                        out_cout  <= sl_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq with a plain-arithmetic model.
// Honours WIDE_ADD_SUB_EN when defined.
module tb_wide_add_seq;

    localparam int W = 60;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    wide_add_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef WIDE_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic sub);
        logic [W:0] r;
`ifdef WIDE_ADD_SUB_EN
        if (sub)
            r = {1'b0, a} + {1'b0, ~b} + 1;
        else
            r = {1'b0, a} + {1'b0, b};
`else
        r = {1'b0, a} + {1'b0, b};
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] rnd60();
        return {$urandom(), $urandom()} & {4'h0, {W{1'b1}}};
    endfunction

    // Accept one operation, check latency, optionally stall in DONE,
    // then complete the handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input int stall,
                          input string tag);
        logic [W:0] exp;
        int cyc;
        exp = model(a, b, sub);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_a = rnd60();
        in_b = rnd60();
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(N));
        chk({tag, "_sum"}, 64'(out_sum), 64'(exp[W-1:0]));
        chk({tag, "_cout"}, 64'(out_cout), 64'(exp[W]));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_hold_v"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_s"}, 64'(out_sum), 64'(exp[W-1:0]));
            chk({tag, "_hold_c"}, 64'(out_cout), 64'(exp[W]));
            chk({tag, "_hold_r"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ret_r"}, 64'(in_ready), 64'd1);
        chk({tag, "_ret_v"}, 64'(out_valid), 64'd0);
    endtask

    logic [W:0] q[$];
    logic [W:0] e;
    int last_acc;
    int n_acc;
    int n_res;
    int cyc;
    bit seen;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        run_op(60'hFFF_FFFF_FFFF_FFFF, 60'd1, 1'b0, 0, "ripple");
        chk("ripple_zero", 64'(out_sum), 64'd0);
        chk("ripple_c1", 64'(out_cout), 64'd1);

        run_op(60'h123_4567_89AB_CDEF, 60'h111_1111_1111_1111, 1'b0, 0,
               "plain");

        run_op(60'h0AA_AAAA_AAAA_AAAA, 60'h055_5555_5555_5555, 1'b0, 5,
               "bp");

        for (int k = 0; k < 6; k++)
            run_op(rnd60(), rnd60(), 1'b0, k % 2, "rand");

`ifdef WIDE_ADD_SUB_EN
        run_op(60'd5, 60'd7, 1'b1, 0, "sub_neg");
        chk("sub_neg_k", 64'(out_sum), 64'h0FFF_FFFF_FFFF_FFFE);
        run_op(60'd7, 60'd5, 1'b1, 0, "sub_pos");
        chk("sub_pos_k", 64'(out_sum), 64'd2);
        for (int k = 0; k < 4; k++)
            run_op(rnd60(), rnd60(), 1'b1, 0, "sub_rand");
`endif

        // Abort mid-operation with idx == 2
        in_a = 60'h0FF_FFFF_FFFF_FFFF;
        in_b = 60'h0FF_FFFF_FFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_rdy", 64'(in_ready), 64'd1);
        chk("abort_v", 64'(out_valid), 64'd0);
        chk("abort_sum", 64'(out_sum), 64'd0);
        chk("abort_cout", 64'(out_cout), 64'd0);
        chk("abort_busy0", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_res", 64'(seen), 64'd0);

        // Back-to-back with in_valid held high
        in_a = rnd60();
        in_b = rnd60();
        in_sub = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        last_acc = -1;
        n_acc = 0;
        n_res = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            seen = in_ready;
            if (seen) begin
                q.push_back(model(in_a, in_b, 1'b0));
                if (last_acc >= 0)
                    chk("b2b_gap", 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
                n_acc++;
            end
            if (out_valid) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("b2b_sum", 64'(out_sum), 64'(e[W-1:0]));
                    chk("b2b_cout", 64'(out_cout), 64'(e[W]));
                end else begin
                    chk("b2b_spur", 64'd1, 64'd0);
                end
                n_res++;
            end
            tick();
            if (seen) begin
                in_a = rnd60();
                in_b = rnd60();
            end
        end
        in_valid = 1'b0;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            if (out_valid) begin
                e = q.pop_front();
                chk("b2b_sum", 64'(out_sum), 64'(e[W-1:0]));
                chk("b2b_cout", 64'(out_cout), 64'(e[W]));
                n_res++;
            end
            tick();
            cyc++;
        end
        chk("b2b_count", 64'(n_res), 64'(n_acc));
        chk("b2b_min", 64'(n_acc >= 6), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
